// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester handshake bus plus FIFO write port shared by the arbiter
//   req_valid/req_data/req_last/req_ready : per-requester beat handshake
//   fifo_wr_en/fifo_wr_data/fifo_full     : FIFO write side
//   grant_id/busy                         : current owner status
//   slave modport = arbiter side, master modport = producers/FIFO side
interface fifo_wr_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int N_REQ = 4
);
    localparam int GW = $clog2(N_REQ);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_last;
    logic [N_REQ-1:0]       req_ready;
    logic                   fifo_wr_en;
    logic [WIDTH-1:0]       fifo_wr_data;
    logic                   fifo_full;
    logic [GW-1:0]          grant_id;
    logic                   busy;
    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
    );
    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among N_REQ producers
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : slave side of fifo_wr_arbiter_if (requester handshakes, FIFO write port, grant status)
module fifo_wr_arbiter #(
    parameter int WIDTH     = 4,
    parameter int N_REQ     = 4,
    parameter int BURST_MAX = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    fifo_wr_arbiter_if.slave    bus
);
    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(BURST_MAX + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] last_q, last_d, grant_q, grant_d, winner, idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          found, busy, own_valid, own_last, beat, at_max, rel;

    // Search starts just after the previous winner, so it is lowest priority next time.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = GW'((int'(last_q) + i) % N_REQ);
            if (!found && bus.req_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign busy      = state_q == OWN;
    assign own_valid = bus.req_valid[grant_q];
    assign own_last  = bus.req_last[grant_q];
    assign beat      = busy && own_valid && !bus.fifo_full;
    assign at_max    = cnt_q == CW'(BURST_MAX - 1);
    // An idle owner only forfeits the grant when the FIFO could have taken its beat.
    assign rel       = busy && (beat ? (own_last || at_max) : (!own_valid && !bus.fifo_full));

    always_comb begin
        state_d = busy ? (rel ? IDLE : OWN) : (found ? OWN : IDLE);
        grant_d = (!busy && found) ? winner : grant_q;
        last_d  = rel ? grant_q : last_q;
        cnt_d   = busy ? cnt_q + CW'(beat) : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            last_q  <= GW'(N_REQ - 1);
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy         = busy;
    assign bus.grant_id     = grant_q;
    assign bus.req_ready    = (busy && !bus.fifo_full) ? N_REQ'(1) << grant_q : '0;
    assign bus.fifo_wr_en   = beat;
    assign bus.fifo_wr_data = busy ? bus.req_data[grant_q*WIDTH +: WIDTH] : '0;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: vector table, directed corner sequences and randomized model check for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    localparam int W  = 4;
    localparam int N  = 4;
    localparam int BM = 4;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    fifo_wr_arbiter_if #(.WIDTH(W), .N_REQ(N)) bus();
    fifo_wr_arbiter #(.WIDTH(W), .N_REQ(N), .BURST_MAX(BM)) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    always @(negedge i_clk) if (bus.fifo_wr_en) wr_cnt++;

    typedef struct {
        logic [N-1:0]   v;
        logic [N-1:0]   l;
        logic           f;
        logic [N*W-1:0] d;
        logic           b;
        int             g;
        logic [N-1:0]   r;
        logic           w;
        logic [W-1:0]   wd;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic f, input logic [N*W-1:0] d);
        bus.req_valid = v;
        bus.req_last  = l;
        bus.fifo_full = f;
        bus.req_data  = d;
    endtask

    task automatic step;
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_out(input string t, input int b, input int g, input int r, input int w, input int wd);
        chk({t, " busy"}, int'(bus.busy), b);
        if (b != 0) chk({t, " grant"}, int'(bus.grant_id), g);
        chk({t, " ready"}, int'(bus.req_ready), r);
        chk({t, " wr_en"}, int'(bus.fifo_wr_en), w);
        chk({t, " wr_data"}, int'(bus.fifo_wr_data), wd);
    endtask

    task automatic do_reset;
        i_rst_n = 1'b0;
        drive('0, '0, 1'b0, '0);
        @(negedge i_clk);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset grant", int'(bus.grant_id), 0);
        chk("reset ready", int'(bus.req_ready), 0);
        chk("reset wr_en", int'(bus.fifo_wr_en), 0);
        chk("reset wr_data", int'(bus.fifo_wr_data), 0);
        step;
        i_rst_n = 1'b1;
    endtask

    // reference model state and random producers
    int           m_owner, m_last, m_cnt, m_beats, pick, own, w0, w1;
    logic         eb, ew, full;
    logic [N-1:0] er, gv, gl, acc;
    logic [W-1:0] ed;
    logic [W-1:0] gd[N];
    logic [N*W-1:0] dd;
    int           iq[N][$];

    initial begin
        tbl[0]  = '{4'b0100, 4'b0000, 1'b0, 16'h0100, 1'b0, 0, 4'b0000, 1'b0, 4'h0};
        tbl[1]  = '{4'b0100, 4'b0000, 1'b0, 16'h0A00, 1'b1, 2, 4'b0100, 1'b1, 4'hA};
        tbl[2]  = '{4'b0100, 4'b0000, 1'b0, 16'h0B00, 1'b1, 2, 4'b0100, 1'b1, 4'hB};
        tbl[3]  = '{4'b0100, 4'b0100, 1'b0, 16'h0C00, 1'b1, 2, 4'b0100, 1'b1, 4'hC};
        tbl[4]  = '{4'b0010, 4'b0000, 1'b0, 16'h0050, 1'b0, 0, 4'b0000, 1'b0, 4'h0};
        tbl[5]  = '{4'b0010, 4'b0000, 1'b1, 16'h0050, 1'b1, 1, 4'b0000, 1'b0, 4'h5};
        tbl[6]  = '{4'b0000, 4'b0000, 1'b1, 16'h0050, 1'b1, 1, 4'b0000, 1'b0, 4'h5};
        tbl[7]  = '{4'b0010, 4'b0000, 1'b0, 16'h0060, 1'b1, 1, 4'b0010, 1'b1, 4'h6};
        tbl[8]  = '{4'b0000, 4'b0000, 1'b0, 16'h0060, 1'b1, 1, 4'b0010, 1'b0, 4'h6};
        tbl[9]  = '{4'b0001, 4'b0000, 1'b0, 16'h0007, 1'b0, 0, 4'b0000, 1'b0, 4'h0};
        tbl[10] = '{4'b0001, 4'b0001, 1'b0, 16'h0007, 1'b1, 0, 4'b0001, 1'b1, 4'h7};
        tbl[11] = '{4'b0000, 4'b0000, 1'b0, 16'h0000, 1'b0, 0, 4'b0000, 1'b0, 4'h0};

        do_reset;
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].v, tbl[i].l, tbl[i].f, tbl[i].d);
            @(negedge i_clk);
            chk_out($sformatf("vec%0d", i), tbl[i].b, tbl[i].g, tbl[i].r, tbl[i].w, tbl[i].wd);
            step;
        end

        // all requesters busy: blocks of BM beats, grants 0,1,2,3,0 with one idle cycle between
        do_reset;
        drive(4'hF, 4'h0, 1'b0, 16'h3210);
        w0 = wr_cnt;
        for (int r = 0; r < 5; r++) begin
            @(negedge i_clk);
            chk($sformatf("rr gap%0d busy", r), int'(bus.busy), 0);
            step;
            for (int b = 0; b < ((r < 4) ? BM : 1); b++) begin
                @(negedge i_clk);
                chk_out($sformatf("rr g%0d b%0d", r, b), 1, r % N, 1 << (r % N), 1, r % N);
                step;
            end
        end
        chk("rr total beats", wr_cnt - w0, 4 * BM + 1);

        // backpressure: requester 1, full for 5 cycles after beat 2, burst resumes and ends at BM
        do_reset;
        drive(4'b0010, 4'h0, 1'b0, 16'h0000);
        @(negedge i_clk);
        chk("bp idle busy", int'(bus.busy), 0);
        step;
        for (int b = 1; b <= BM; b++) begin
            if (b == 3) begin
                drive(4'b0010, 4'h0, 1'b1, 16'(b << 4));
                for (int c = 0; c < 5; c++) begin
                    @(negedge i_clk);
                    chk_out($sformatf("bp full%0d", c), 1, 1, 0, 0, b);
                    step;
                end
            end
            drive(4'b0010, 4'h0, 1'b0, 16'(b << 4));
            @(negedge i_clk);
            chk_out($sformatf("bp beat%0d", b), 1, 1, 4'b0010, 1, b);
            step;
        end
        @(negedge i_clk);
        chk("bp release busy", int'(bus.busy), 0);
        step;

        // owner 0 goes idle after one beat; requester 3 wins next despite 0 re-asserting
        do_reset;
        drive(4'b1001, 4'h0, 1'b0, 16'h9001);
        @(negedge i_clk);
        chk("drop idle busy", int'(bus.busy), 0);
        step;
        @(negedge i_clk);
        chk_out("drop beat1", 1, 0, 4'b0001, 1, 1);
        step;
        drive(4'b1000, 4'h0, 1'b0, 16'h9001);
        @(negedge i_clk);
        chk_out("drop idle owner", 1, 0, 4'b0001, 0, 1);
        step;
        drive(4'b1001, 4'h0, 1'b0, 16'h9001);
        @(negedge i_clk);
        chk("drop gap busy", int'(bus.busy), 0);
        step;
        @(negedge i_clk);
        chk_out("drop next grant", 1, 3, 4'b1000, 1, 9);
        step;

        // asynchronous reset during beat 2
        do_reset;
        drive(4'hF, 4'h0, 1'b0, 16'h3210);
        w0 = wr_cnt;
        @(negedge i_clk);
        step;
        @(negedge i_clk);
        chk_out("arst beat1", 1, 0, 4'b0001, 1, 0);
        step;
        #2 i_rst_n = 1'b0;
        #1;
        chk_out("arst async", 0, 0, 0, 0, 0);
        @(negedge i_clk);
        step;
        i_rst_n = 1'b1;
        w1 = wr_cnt;
        chk("arst beats before reset", w1 - w0, 1);
        @(negedge i_clk);
        chk("arst idle busy", int'(bus.busy), 0);
        step;
        @(negedge i_clk);
        chk_out("arst first winner", 1, 0, 4'b0001, 1, 0);
        step;

        // randomized traffic against the reference model and per-requester scoreboard
        do_reset;
        m_owner = -1;
        m_last  = N - 1;
        m_cnt   = 0;
        m_beats = 0;
        gv      = '0;
        gl      = '0;
        full    = 1'b0;
        for (int k = 0; k < N; k++) gd[k] = '0;
        w0 = wr_cnt;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int k = 0; k < N; k++) dd[k*W +: W] = gd[k];
            drive(gv, gl, full, dd);
            @(negedge i_clk);
            eb  = m_owner >= 0;
            own = eb ? m_owner : 0;
            ew  = eb && gv[own] && !full;
            er  = (eb && !full) ? N'(1) << own : '0;
            ed  = eb ? gd[own] : '0;
            chk_out("rnd", int'(eb), own, int'(er), int'(ew), int'(ed));
            chk("rnd wr_en while full", int'(bus.fifo_wr_en && bus.fifo_full), 0);
            chk("rnd ready onehot", int'($countones(bus.req_ready) > 1), 0);
            if (bus.fifo_wr_en) begin
                if (iq[bus.grant_id].size() == 0) chk("rnd sb empty", 1, 0);
                else chk("rnd sb order", int'(bus.fifo_wr_data), iq[bus.grant_id].pop_front());
            end
            acc = bus.req_ready & gv;
            if (!eb) begin
                pick = -1;
                for (int i = 1; i <= N; i++)
                    if (pick < 0 && gv[(m_last + i) % N]) pick = (m_last + i) % N;
                m_owner = pick;
                m_cnt   = 0;
            end else if (ew) begin
                m_beats++;
                m_cnt++;
                if (gl[own] || m_cnt == BM) begin
                    m_last  = own;
                    m_owner = -1;
                end
            end else if (!gv[own] && !full) begin
                m_last  = own;
                m_owner = -1;
            end
            step;
            for (int k = 0; k < N; k++) begin
                if (acc[k] || !gv[k]) begin
                    gv[k] = ($urandom % 3) != 0;
                    if (gv[k]) begin
                        gd[k] = W'($urandom);
                        gl[k] = ($urandom % 4) == 0;
                        iq[k].push_back(int'(gd[k]));
                    end
                end
            end
            full = ($urandom % 4) == 0;
        end
        chk("rnd total beats", wr_cnt - w0, m_beats);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
